// File: rtl/dpram_2kx5_if.sv
// Bus bundle for the 2K x 5 true dual-port RAM.
// Carries both user ports plus the clear-sweep busy flag.
interface dpram_2kx5_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 5
);
  logic [ADDR_W-1:0] address_a;
  logic [DATA_W-1:0] data_a;
  logic              wren_a;
  logic              rden_a;
  logic [DATA_W-1:0] q_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_b;
  logic              wren_b;
  logic              rden_b;
  logic [DATA_W-1:0] q_b;
  logic              busy;

  modport master (
    output address_a, data_a, wren_a, rden_a,
    output address_b, data_b, wren_b, rden_b,
    input  q_a, q_b, busy
  );

  modport slave (
    input  address_a, data_a, wren_a, rden_a,
    input  address_b, data_b, wren_b, rden_b,
    output q_a, q_b, busy
  );
endinterface

// File: rtl/dpram_2kx5.sv
// 2K x 5 true dual-port RAM, registered reads, port A wins collisions.
// Define DPRAM_CLEAR_EN to zero the array with a sweep after reset.
module dpram_2kx5 #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  dpram_2kx5_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q_a;
  logic [DATA_W-1:0] r_q_b;

  logic              w_busy;
  logic              w_ok;
  logic              w_we_a;
  logic              w_we_b;
  logic              w_re_a;
  logic              w_re_b;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

`ifdef DPRAM_CLEAR_EN
  logic              r_busy;
  logic [ADDR_W-1:0] r_cnt;

  // Busy falls on the same edge that zeroes the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {ADDR_W{1'b1}}) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign w_busy     = r_busy;
  assign w_clr_we   = r_busy & reset_n;
  assign w_clr_addr = r_cnt;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_ok   = reset_n & ~w_busy;
  assign w_we_a = w_ok & bus.wren_a;
  assign w_we_b = w_ok & bus.wren_b &
                  ~(bus.wren_a &
                    (bus.address_a == bus.address_b));
  assign w_re_a = w_ok & bus.rden_a;
  assign w_re_b = w_ok & bus.rden_b;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_we_a) begin
        r_mem[bus.address_a] <= bus.data_a;
      end
      if (w_we_b) begin
        r_mem[bus.address_b] <= bus.data_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_a <= '0;
    end else if (w_re_a) begin
      r_q_a <= r_mem[bus.address_a];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_b <= '0;
    end else if (w_re_b) begin
      r_q_b <= r_mem[bus.address_b];
    end
  end

  assign bus.q_a  = r_q_a;
  assign bus.q_b  = r_q_b;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_dpram_2kx5.sv
// Directed bench for dpram_2kx5; define DPRAM_CLEAR_EN
// to also exercise the clear sweep.
module tb_dpram_2kx5;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  dpram_2kx5_if #(.ADDR_W(11), .DATA_W(5)) bus ();

  dpram_2kx5 #(.ADDR_W(11), .DATA_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wren_a = 1'b0;
    bus.rden_a = 1'b0;
    bus.wren_b = 1'b0;
    bus.rden_b = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk(tag, {15'd0, bus.busy}, 16'd0);
  endtask

  task automatic wr_a(input logic [10:0] a,
                      input logic [4:0] d);
    idle();
    bus.address_a = a;
    bus.data_a    = d;
    bus.wren_a    = 1'b1;
    tick();
    idle();
  endtask

  logic [4:0] exp5;
  logic [4:0] exp7ff;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.address_a = '0;
    bus.address_b = '0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    idle();
    #3;
    chk("rst_q_a", {11'd0, bus.q_a}, 16'd0);
    chk("rst_q_b", {11'd0, bus.q_b}, 16'd0);
`ifdef DPRAM_CLEAR_EN
    chk("rst_busy", {15'd0, bus.busy}, 16'd1);
`else
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
    wait_ready("init_ready");

    // A writes, B reads back next cycle
    wr_a(11'h005, 5'h1F);
    bus.address_b = 11'h005;
    bus.rden_b    = 1'b1;
    tick();
    idle();
    chk("a_wr_b_rd", {11'd0, bus.q_b}, 16'h1F);

    // same-address collision: A wins
    bus.address_a = 11'h7FF;
    bus.data_a    = 5'h0A;
    bus.wren_a    = 1'b1;
    bus.address_b = 11'h7FF;
    bus.data_b    = 5'h15;
    bus.wren_b    = 1'b1;
    tick();
    idle();
    bus.rden_a = 1'b1;
    bus.rden_b = 1'b1;
    tick();
    idle();
    chk("coll_q_a", {11'd0, bus.q_a}, 16'h0A);
    chk("coll_q_b", {11'd0, bus.q_b}, 16'h0A);

    // dual write to different addresses
    bus.address_a = 11'h010;
    bus.data_a    = 5'h01;
    bus.wren_a    = 1'b1;
    bus.address_b = 11'h011;
    bus.data_b    = 5'h02;
    bus.wren_b    = 1'b1;
    tick();
    idle();
    bus.address_a = 11'h011;
    bus.rden_a    = 1'b1;
    bus.address_b = 11'h010;
    bus.rden_b    = 1'b1;
    tick();
    idle();
    chk("dual_q_a", {11'd0, bus.q_a}, 16'h02);
    chk("dual_q_b", {11'd0, bus.q_b}, 16'h01);

    // mixed-port read during write
    wr_a(11'h100, 5'h03);
    bus.address_a = 11'h100;
    bus.data_a    = 5'h1C;
    bus.wren_a    = 1'b1;
    bus.address_b = 11'h100;
    bus.rden_b    = 1'b1;
    tick();
    idle();
    chk("mix_old", {11'd0, bus.q_b}, 16'h03);
    bus.rden_b = 1'b1;
    tick();
    idle();
    chk("mix_new", {11'd0, bus.q_b}, 16'h1C);

    // same-port read during write
    wr_a(11'h200, 5'h07);
    bus.address_a = 11'h200;
    bus.data_a    = 5'h19;
    bus.wren_a    = 1'b1;
    bus.rden_a    = 1'b1;
    tick();
    idle();
    chk("same_old", {11'd0, bus.q_a}, 16'h07);
    bus.rden_a = 1'b1;
    tick();
    idle();
    chk("same_new", {11'd0, bus.q_a}, 16'h19);

    // neighbour write leaves 0x7FF intact
    wr_a(11'h7FE, 5'h04);
    bus.address_b = 11'h7FF;
    bus.rden_b    = 1'b1;
    tick();
    idle();
    chk("nbr_7ff", {11'd0, bus.q_b}, 16'h0A);

    // hold with rden_a low
    bus.address_a = 11'h005;
    bus.rden_a    = 1'b1;
    tick();
    idle();
    chk("hold_load", {11'd0, bus.q_a}, 16'h1F);
    for (int i = 0; i < 5; i++) begin
      bus.address_a = 11'h010 + 11'(i);
      tick();
    end
    chk("hold_5cyc", {11'd0, bus.q_a}, 16'h1F);

    // async reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_q_a", {11'd0, bus.q_a}, 16'h00);
    chk("async_q_b", {11'd0, bus.q_b}, 16'h00);
    bus.address_a = 11'h005;
    bus.data_a    = 5'h00;
    bus.wren_a    = 1'b1;
    bus.rden_a    = 1'b1;
    tick();
    tick();
    chk("rst_hold_q", {11'd0, bus.q_a}, 16'h00);
    idle();
    reset_n = 1'b1;
    wait_ready("rst2_ready");
`ifdef DPRAM_CLEAR_EN
    exp5   = 5'h00;
    exp7ff = 5'h00;
`else
    exp5   = 5'h1F;
    exp7ff = 5'h0A;
`endif
    bus.address_a = 11'h005;
    bus.rden_a    = 1'b1;
    bus.address_b = 11'h7FF;
    bus.rden_b    = 1'b1;
    tick();
    idle();
    chk("post_rst_5", {11'd0, bus.q_a}, {11'd0, exp5});
    chk("post_rst_7ff", {11'd0, bus.q_b}, {11'd0, exp7ff});

`ifdef DPRAM_CLEAR_EN
    wr_a(11'h7FF, 5'h11);
    bus.address_a = 11'h7FF;
    bus.rden_a    = 1'b1;
    tick();
    idle();
    chk("clr_fill", {11'd0, bus.q_a}, 16'h11);
    #2;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    bus.address_a = 11'h7FF;
    bus.data_a    = 5'h1E;
    bus.wren_a    = 1'b1;
    bus.rden_a    = 1'b1;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
      if (cyc == 2040) begin
        chk("clr_q_zero", {11'd0, bus.q_a}, 16'h00);
        idle();
      end
    end
    idle();
    chk("clr_cycles", cyc[15:0], 16'd2048);
    bus.rden_a = 1'b1;
    tick();
    idle();
    chk("clr_7ff", {11'd0, bus.q_a}, 16'h00);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
